// File: rtl/div_seq_pkg.sv
// div_seq_pkg: op encodings, FSM states and width constants for the divide sequencer
package div_seq_pkg;
    localparam int XLEN_DEF = 32;
    localparam logic [XLEN_DEF-1:0] INT_MIN = {1'b1, {(XLEN_DEF-1){1'b0}}};
    typedef enum logic [1:0] {OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11} op_e;
    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_FIX, S_DONE} state_e;
    function automatic logic op_signed(input logic [1:0] op);
        return ~op[0];
    endfunction
    function automatic logic op_rem(input logic [1:0] op);
        return op[1];
    endfunction
endpackage

// File: rtl/div_sign_fix.sv
// div_sign_fix: operand magnitude conversion and signed quotient/remainder correction
import div_seq_pkg::*;
module div_sign_fix #(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            is_signed,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            sign_a,
    output logic            sign_b,
    output logic [XLEN:0]   mag_a,
    output logic [XLEN:0]   mag_b,
    input  logic [XLEN-1:0] q,
    input  logic [XLEN-1:0] r,
    input  logic            neg_q,
    input  logic            neg_r,
    input  logic            sel_rem,
    output logic [XLEN-1:0] q_fix,
    output logic [XLEN-1:0] r_fix,
    output logic [XLEN-1:0] res
);
    always_comb begin
        sign_a = is_signed & a[XLEN-1];
        sign_b = is_signed & b[XLEN-1];
        // negate the sign-extended value so INT_MIN yields 2^(XLEN-1)
        mag_a = sign_a ? -{a[XLEN-1], a} : {1'b0, a};
        mag_b = sign_b ? -{b[XLEN-1], b} : {1'b0, b};
        q_fix = neg_q ? -q : q;
        r_fix = neg_r ? -r : r;
        res = sel_rem ? r_fix : q_fix;
    end
endmodule

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: DIV/DIVU/REM/REMU sequencer around an external unsigned divider core
// DIV_RESULT_CACHE_EN adds a one-entry cache of the last completed core result.
import div_seq_pkg::*;
module div_seq_ctrl #(
    parameter int XLEN = XLEN_DEF,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             div_en,
    output logic [XLEN:0]    div_dividend,
    output logic [XLEN:0]    div_divisor,
    input  logic             div_ready,
    input  logic             div_vout,
    input  logic [XLEN:0]    div_q,
    input  logic [XLEN:0]    div_r
);
    localparam logic [XLEN-1:0] IMIN = {1'b1, {(XLEN-1){1'b0}}};
    state_e state, state_nx;
    logic accept, sgn_in, sa_in, sb_in, dz, ovf, hit;
    logic sa_r, sb_r, rem_r;
    logic [XLEN:0] mag_a, mag_b;
    logic [XLEN-1:0] q_r, r_r, q_fix, r_fix, res, special, hit_data;
    logic unused_msb;
    assign unused_msb = div_q[XLEN] ^ div_r[XLEN];
    assign sgn_in = op_signed(in_op);
    assign dz = in_b == '0;
    assign ovf = sgn_in && in_a == IMIN && in_b == '1;
    assign special = dz ? (op_rem(in_op) ? in_a : '1) : (op_rem(in_op) ? '0 : IMIN);

    div_sign_fix #(.XLEN(XLEN)) u_fix (
        .is_signed(sgn_in), .a(in_a), .b(in_b), .sign_a(sa_in), .sign_b(sb_in),
        .mag_a(mag_a), .mag_b(mag_b), .q(q_r), .r(r_r), .neg_q(sa_r ^ sb_r),
        .neg_r(sa_r), .sel_rem(rem_r), .q_fix(q_fix), .r_fix(r_fix), .res(res)
    );

`ifdef DIV_RESULT_CACHE_EN
    logic [XLEN-1:0] a_r, b_r, c_a, c_b, c_q, c_r;
    logic sgn_r, c_sgn, c_v;
    always_ff @(posedge clk) begin
        if (accept && !flush) begin
            a_r <= in_a;
            b_r <= in_b;
            sgn_r <= sgn_in;
        end
        if (!reset_n) c_v <= 1'b0;
        else if (state == S_FIX && !flush) begin
            c_v <= 1'b1;
            c_a <= a_r;
            c_b <= b_r;
            c_sgn <= sgn_r;
            c_q <= q_fix;
            c_r <= r_fix;
        end
    end
    assign hit = c_v && c_a == in_a && c_b == in_b && c_sgn == sgn_in;
    assign hit_data = op_rem(in_op) ? c_r : c_q;
`else
    assign hit = 1'b0;
    assign hit_data = '0;
`endif

    always_ff @(posedge clk) state <= !reset_n ? S_IDLE : state_nx;

    always_comb begin
        state_nx = state;
        in_ready = state == S_IDLE;
        out_valid = state == S_DONE;
        div_en = state == S_LAUNCH && div_ready;
        accept = in_ready && in_valid;
        case (state)
            S_IDLE:   state_nx = accept ? ((dz || ovf || hit) ? S_DONE : S_LAUNCH) : S_IDLE;
            S_LAUNCH: state_nx = div_ready ? S_WAIT : S_LAUNCH;
            S_WAIT:   state_nx = div_vout ? S_FIX : S_WAIT;
            S_FIX:    state_nx = S_DONE;
            S_DONE:   state_nx = out_ready ? S_IDLE : S_DONE;
            default:  state_nx = S_IDLE;
        endcase
        if (flush) state_nx = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_data <= '0;
            out_tag <= '0;
            div_dividend <= '0;
            div_divisor <= '0;
            sa_r <= 1'b0;
            sb_r <= 1'b0;
            rem_r <= 1'b0;
        end else begin
            if (accept && !flush) begin
                out_tag <= in_tag;
                rem_r <= op_rem(in_op);
                sa_r <= sa_in;
                sb_r <= sb_in;
                div_dividend <= mag_a;
                div_divisor <= mag_b;
                if (dz || ovf) out_data <= special;
                else if (hit) out_data <= hit_data;
            end
            // the core remainder keeps shifting after the strobe, so sample only here
            if (state == S_WAIT && div_vout) begin
                q_r <= div_q[XLEN-1:0];
                r_r <= div_r[XLEN-1:0];
            end
            if (state == S_FIX) out_data <= res;
        end
    end
endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: randomized bench for div_seq_ctrl with a behavioural divider core and reference model
import div_seq_pkg::*;
module tb_div_seq_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [1:0] in_op = 2'b00;
    logic [31:0] in_a = '0, in_b = '0;
    logic [4:0] in_tag = '0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic [31:0] out_data;
    logic [4:0] out_tag;
    logic div_en;
    logic [32:0] div_dividend, div_divisor;
    logic div_ready = 1'b1;
    logic div_vout = 1'b0;
    logic [32:0] div_q = '0, div_r = '0;
    logic [32:0] cq = '0, cr = '0;
    int busy = 0;
    int core_lat = 4;
    int en_count = 0;
    int errors = 0;
    int checks = 0;
`ifdef DIV_RESULT_CACHE_EN
    logic cv = 1'b0;
    logic csg = 1'b0;
    logic [31:0] ca = '0, cb = '0;
`endif

    always #5 clk = ~clk;

    div_seq_ctrl dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag), .div_en(div_en),
        .div_dividend(div_dividend), .div_divisor(div_divisor), .div_ready(div_ready),
        .div_vout(div_vout), .div_q(div_q), .div_r(div_r)
    );

    // Divider core: busy for core_lat cycles, one-cycle strobe, garbage outside the strobe
    always @(posedge clk) begin
        div_vout <= 1'b0;
        div_q <= {1'b0, 32'($urandom)};
        div_r <= {1'b0, 32'($urandom)};
        if (div_en) en_count <= en_count + 1;
        if (busy > 0) begin
            busy <= busy - 1;
            if (busy == 1) begin
                div_vout <= 1'b1;
                div_q <= cq;
                div_r <= cr;
                div_ready <= 1'b1;
            end
        end else if (div_en && div_ready) begin
            cq <= div_divisor != 0 ? div_dividend / div_divisor : '1;
            cr <= div_divisor != 0 ? div_dividend % div_divisor : div_dividend;
            busy <= core_lat;
            div_ready <= 1'b0;
        end
    end

    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return op[1] ? a % b : a / b;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return $urandom;
            1: return $urandom_range(0, 20);
            2: return INT_MIN;
            3: return 32'hFFFF_FFFF;
            4: return 32'd0;
            default: return -$urandom_range(1, 20);
        endcase
    endfunction

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int hold);
        logic [4:0] tag;
        logic [31:0] d0;
        logic sgn, fast;
        bit bad, bad_hold;
        int en0, cyc, vcyc;
        tag = 5'($urandom);
        sgn = !op[0];
        fast = (b == 0) || (sgn && a == INT_MIN && b == 32'hFFFF_FFFF);
`ifdef DIV_RESULT_CACHE_EN
        fast = fast || (cv && ca == a && cb == b && csg == sgn);
`endif
        core_lat = $urandom_range(1, 8);
        out_ready = (hold == 0);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL %s accept: in_ready=%b want 1", name, in_ready); end
        en0 = en_count; bad = 0; vcyc = -10; cyc = 0;
        do begin
            @(posedge clk); #1;
            in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_tag = 5'($urandom);
            cyc++;
            if (in_ready !== 1'b0 || (div_en && !div_ready)) bad = 1;
            if (div_vout) vcyc = cyc;
        end while (out_valid !== 1'b1 && cyc < 300);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: out_valid=%b want 1", name, out_valid);
            flush = 1'b1; @(posedge clk); #1; flush = 1'b0; out_ready = 1'b1;
            return;
        end
        checks++;
        if (out_data !== exp) begin errors++; $display("FAIL %s data: got %h want %h", name, out_data, exp); end
        checks++;
        if (out_tag !== tag) begin errors++; $display("FAIL %s tag: got %h want %h", name, out_tag, tag); end
        checks++;
        if (bad) begin errors++; $display("FAIL %s busy: in_ready high or div_en without div_ready (got 1 want 0)", name); end
        checks++;
        if (fast ? cyc != 1 : cyc != vcyc + 2)
            begin errors++; $display("FAIL %s latency: got %0d want %0d", name, cyc, fast ? 1 : vcyc + 2); end
        checks++;
        if (en_count - en0 != (fast ? 0 : 1))
            begin errors++; $display("FAIL %s div_en cycles: got %0d want %0d", name, en_count - en0, fast ? 0 : 1); end
        d0 = out_data; bad_hold = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || out_data !== d0 || out_tag !== tag || in_ready !== 1'b0) bad_hold = 1;
        end
        if (hold > 0) begin
            checks++;
            if (bad_hold) begin errors++; $display("FAIL %s hold: outputs changed under backpressure (got 1 want 0)", name); end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin errors++; $display("FAIL %s release: in_ready=%b out_valid=%b want 1 0", name, in_ready, out_valid); end
`ifdef DIV_RESULT_CACHE_EN
        if (!fast) begin cv = 1'b1; ca = a; cb = b; csg = sgn; end
`endif
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks += 4;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
        if (out_valid !== 1'b0 || div_en !== 1'b0)
            begin errors++; $display("FAIL reset valid/en: got %b %b want 0 0", out_valid, div_en); end
        if (out_data !== '0 || out_tag !== '0)
            begin errors++; $display("FAIL reset data/tag: got %h %h want 0 0", out_data, out_tag); end
        if (div_dividend !== '0 || div_divisor !== '0)
            begin errors++; $display("FAIL reset mags: got %h %h want 0 0", div_dividend, div_divisor); end
        reset_n = 1'b1;
    endtask

    task automatic test_directed;
        run_op("divu_100_7", OP_DIVU, 100, 7, 14, 0);
        run_op("remu_100_7", OP_REMU, 100, 7, 2, 0);
        run_op("div_m7_2", OP_DIV, -32'd7, 2, 32'hFFFF_FFFD, 0);
        run_op("rem_m7_2", OP_REM, -32'd7, 2, 32'hFFFF_FFFF, 0);
        run_op("rem_7_m2", OP_REM, 7, -32'd2, 1, 0);
        run_op("div_5_0", OP_DIV, 5, 0, 32'hFFFF_FFFF, 0);
        run_op("remu_5_0", OP_REMU, 5, 0, 5, 0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        run_op("div_intmin_1", OP_DIV, 32'h8000_0000, 1, 32'h8000_0000, 0);
    endtask

    task automatic test_backpressure;
        run_op("bp_core", OP_DIVU, 1234, 10, 123, 5);
        run_op("bp_special", OP_REM, 77, 0, 77, 5);
    endtask

    task automatic test_flush;
        int en0;
        core_lat = 25;
        in_valid = 1'b1; in_op = OP_DIVU; in_a = 1000; in_b = 7; in_tag = 5'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL flush_wait: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
        run_op("flush_then_divu", OP_DIVU, 9, 3, 3, 0);
        en0 = en_count;
        in_valid = 1'b1; flush = 1'b1; in_op = OP_DIVU; in_a = 50; in_b = 5;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || en_count != en0)
            begin errors++; $display("FAIL flush_accept: out_valid=%b in_ready=%b en=%0d want 0 1 0", out_valid, in_ready, en_count - en0); end
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = OP_DIV; in_a = 5; in_b = 0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_done setup: out_valid=%b want 1", out_valid); end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL flush_done: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
    endtask

    task automatic test_reset_mid;
        core_lat = 20;
        in_valid = 1'b1; in_op = OP_DIV; in_a = -32'd999; in_b = 4; in_tag = 5'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
`ifdef DIV_RESULT_CACHE_EN
        cv = 1'b0;
`endif
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0)
            begin errors++; $display("FAIL reset_mid: out_valid=%b in_ready=%b data=%h want 0 1 0", out_valid, in_ready, out_data); end
        run_op("reset_then_rem", OP_REM, -32'd17, 5, -32'd2, 0);
    endtask

    task automatic test_cache;
        run_op("cache_div", OP_DIV, 100, 7, 14, 0);
        run_op("cache_rem", OP_REM, 100, 7, 2, 0);
    endtask

    task automatic test_random;
        logic [31:0] a, b;
        logic [1:0] op;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom);
            a = pick();
            b = pick();
            run_op("random", op, a, b, ref_div(op, a, b), $urandom_range(0, 2));
        end
    endtask

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_cache();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/div_seq_ctrl.md
# div_seq_ctrl

Sequencer for the RISC-V M-extension divide/remainder path of the core. Accepts DIV/DIVU/REM/REMU requests from execute with a valid/ready handshake. Converts signed operands to magnitudes and launches the external unsigned radix-8 divider core. It then captures its one-cycle result strobe, applies sign correction, handles divide-by-zero and signed overflow without using the core, and returns a tagged result under backpressure.

## Interface
- XLEN, 32: architectural operand width; divider core width is XLEN+1.
- TAG_W, 5: destination tag width, echoed unchanged.

- clk  in  1  clock, all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- flush  in  1  kill any in-flight op.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- in_a, in_b  in  XLEN each  dividend, divisor.
- in_tag  in  TAG_W  destination tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_data  out  XLEN  result.
- out_tag  out  TAG_W  tag of result.
- div_en  out  1  core start.
- div_dividend, div_divisor  out  XLEN+1 each  zero-extended magnitudes.
- div_ready  in  1  core idle.
- div_vout  in  1  core result strobe, exactly one cycle.
- div_q, div_r  in  XLEN+1 each  core quotient, remainder; valid only in the div_vout cycle.

## Operation
- States: IDLE, LAUNCH, WAIT, FIX, DONE.
- IDLE: in_ready=1. On accept, register op, tag, operands, sign flags and magnitudes.
  - Magnitudes are computed in XLEN+1 bits so that INT_MIN maps to 2^(XLEN-1).
  - Unsigned ops use the raw operands and clear the sign flags.
  - The state then moves to LAUNCH, or to DONE on a special case.
- Divide-by-zero (b==0):
  - Quotient = all ones.
  - Remainder = a.
  - Goes to DONE, and the core is not started.
- Signed overflow (DIV/REM, a==INT_MIN, b==-1):
  - Quotient = INT_MIN.
  - Remainder = 0.
  - Goes to DONE.
- LAUNCH:
  - div_en = div_ready. Moves to WAIT in the cycle div_en is high.
  - div_vout seen in LAUNCH is ignored; it is the stale strobe of a flushed op.
- WAIT: on div_vout, capture div_q/div_r low XLEN bits, then go to FIX. The core's remainder register keeps shifting after the strobe, so it is never sampled later.
- FIX, signed ops:
  - Negate the quotient if sign(a)^sign(b).
  - Negate the remainder if sign(a).
  - Select the quotient or remainder by op, then go to DONE.
- DONE: out_valid=1; out_data and out_tag are stable. The state returns to IDLE on out_ready.
- Flush forces IDLE on the next edge from any state and drops the result (out_valid low next cycle). A flush in the same cycle as an accept wins, and the request is dropped.
- A flushed core op is not aborted; LAUNCH simply waits for div_ready.

## Timing
- Accept at cycle T; div_en no earlier than T+1.
- If div_vout arrives at cycle V, FIX is at V+1 and out_valid at V+2.
- Special cases: out_valid at T+1.
- in_ready=0 from T+1 until the cycle after the out handshake; there is one op in flight at a time.
- Reset (reset_n=0 at an edge):
  - State = IDLE.
  - in_ready=1 after the edge.
  - out_valid=0, out_data=0, out_tag=0, div_en=0, divider magnitudes=0.
- Reset mid-operation behaves like flush. The core keeps its own reset, and its stale strobe is ignored as in flush.

## Configuration
- DIV_RESULT_CACHE_EN: when defined, hold the last completed core op's a, b, signedness, corrected quotient and corrected remainder, plus a valid bit.
  - Valid bit behaviour:
    - Cleared by reset.
    - Set only on a completed core op; flushed and special-case ops do not fill the cache.
  - A request with matching a, b and signedness skips the core and goes to DONE at T+1 with the cached quotient or remainder.
- Undefined: no cache storage; every non-special request uses the core.

## Structure
- Package div_seq_pkg: op encodings, state enum, XLEN default, INT_MIN constant.
- One sub-module, div_sign_fix: a combinational block for magnitude conversion and result negation/selection, shared by the IDLE and FIX paths.

## Test plan
- DIVU 100/7 -> out_data 14; REMU 100/7 -> 2; div_en exactly one cycle.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; REM 7/-2 -> 1.
- DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5 at T+1; div_en never asserted.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0; out_valid at T+1.
- Flush during WAIT, then DIVU 9/3 immediately.
  - div_en waits for div_ready.
  - The stale div_vout is ignored.
  - Result is 3.
- out_ready held low for 5 cycles: out_valid, out_data and out_tag stay stable and in_ready stays 0. With DIV_RESULT_CACHE_EN, DIV 100/7 followed by REM 100/7 -> second result 2 at T+1 without div_en.
